// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - scan-chain transaction sequencer: shift addr+data frame, update, capture reply paced by rtck.
// Optional SCAN_AUTOPOLL_EN adds idle round-robin polling and the poll_flag output.
module scan_sequencer #(
  parameter int TCK_DIV = 4,
  parameter int TIMEOUT = 255,
  parameter int NUM_DES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       tck,
  output logic       tms,
  output logic       tdi,
  input  logic       rtck,
  input  logic       tdo
`ifdef SCAN_AUTOPOLL_EN
  ,
  output logic       poll_flag
`endif
);

  localparam int DW = $clog2(TCK_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, UPDATE, CAPTURE, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [4:0]      bit_cnt;
  logic [TW-1:0]   to_cnt;
  logic [15:0]     frame;
  logic            rtck_s1, rtck_s2, rtck_s3;
  logic            tdo_s1, tdo_s2;

  logic            tck_active;
  logic            tick;
  logic            rtck_rise;
  logic            start;
  logic            start_poll;
  logic [7:0]      start_addr;
  logic [7:0]      start_data;

`ifdef SCAN_AUTOPOLL_EN
  logic [9:0]      idle_cnt;
  logic [7:0]      poll_addr;
`endif

  assign tck_active = (state == SHIFT) || (state == UPDATE) || (state == CAPTURE);
  assign tick       = (div_cnt == DW'(TCK_DIV - 1));
  // tdo is synchronised alongside rtck so the sampled bit lines up with the detected edge
  assign rtck_rise  = rtck_s2 & ~rtck_s3;

  always_comb begin
    start      = req_valid;
    start_poll = 1'b0;
    start_addr = req_addr;
    start_data = req_data;
`ifdef SCAN_AUTOPOLL_EN
    if (!req_valid && idle_cnt == 10'd1023) begin
      start      = 1'b1;
      start_poll = 1'b1;
      start_addr = poll_addr;
      start_data = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      frame      <= '0;
      rtck_s1    <= 1'b0;
      rtck_s2    <= 1'b0;
      rtck_s3    <= 1'b0;
      tdo_s1     <= 1'b0;
      tdo_s2     <= 1'b0;
      tck        <= 1'b0;
      tms        <= 1'b0;
      tdi        <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
`ifdef SCAN_AUTOPOLL_EN
      idle_cnt   <= '0;
      poll_addr  <= 8'd1;
      poll_flag  <= 1'b0;
`endif
    end else begin
      rtck_s1    <= rtck;
      rtck_s2    <= rtck_s1;
      rtck_s3    <= rtck_s2;
      tdo_s1     <= tdo;
      tdo_s2     <= tdo_s1;
      resp_valid <= 1'b0;

      if (tck_active && !tick) div_cnt <= div_cnt + 1'b1;
      else                     div_cnt <= '0;

`ifdef SCAN_AUTOPOLL_EN
      if (state == IDLE && !req_valid && idle_cnt != 10'd1023) idle_cnt <= idle_cnt + 1'b1;
      else                                                     idle_cnt <= '0;
`endif

      case (state)
        IDLE: begin
          if (start) begin
            frame     <= {start_data, start_addr};
            req_ready <= 1'b0;
            bit_cnt   <= '0;
`ifdef SCAN_AUTOPOLL_EN
            poll_flag <= start_poll;
            if (start_poll) poll_addr <= (poll_addr >= 8'(NUM_DES)) ? 8'd1 : poll_addr + 1'b1;
`endif
            if (start_addr == 8'd0 || start_addr > 8'(NUM_DES)) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state <= SHIFT;
              tms   <= 1'b1;
              tdi   <= start_addr[0];
            end
          end
        end

        SHIFT: begin
          if (tick) begin
            tck <= ~tck;
            if (!tck) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == 5'd16) begin
              state <= UPDATE;
              tms   <= 1'b0;
              tdi   <= 1'b0;
            end else begin
              // bit_cnt already counts the rise just taken, so it indexes the next bit
              tdi <= frame[bit_cnt[3:0]];
            end
          end
        end

        UPDATE: begin
          if (tick) begin
            tck <= ~tck;
            if (tck) begin
              state   <= CAPTURE;
              tms     <= 1'b1;
              bit_cnt <= '0;
              to_cnt  <= '0;
            end
          end
        end

        CAPTURE: begin
          if (tick) tck <= ~tck;
          if (rtck_rise) begin
            resp_data <= {tdo_s2, resp_data[7:1]};
            to_cnt    <= '0;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 5'd7) begin
              state      <= DONE;
              tck        <= 1'b0;
              tms        <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
            end
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state      <= DONE;
            tck        <= 1'b0;
            tms        <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          tck       <= 1'b0;
          tms       <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
